// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one word load/store per instruction on a req/ack bus,
// stalls upstream while the transaction is outstanding, and faults on misalignment or timeout.
module mem_access_stage #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_is_load,
  input  logic             in_is_store,
  input  logic [WIDTH-1:0] instruction_in,
  input  logic [WIDTH-3:0] progcounter_in,
  input  logic [WIDTH-1:0] dataC_in,
  input  logic [WIDTH-1:0] addr_in,
  output logic             mem_stall,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_ack,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic             wb_valid,
  output logic             wb_we,
  output logic [WIDTH-1:0] wb_instruction,
  output logic [WIDTH-3:0] wb_progcounter,
  output logic [WIDTH-1:0] wb_data,
  output logic             mem_fault
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic {IDLE, WAIT} state_t;

  // Instruction context held across the bus transaction; addr/data live in dmem_addr/dmem_wdata.
  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-3:0] pc;
    logic             is_load;
  } op_t;

  typedef struct packed {
    logic             req;
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
  } bus_t;

  typedef struct packed {
    logic             valid;
    logic             we;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-3:0] pc;
    logic [WIDTH-1:0] data;
    logic             fault;
  } wb_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  op_t             lat, lat_nxt;
  bus_t            bus, bus_nxt;
  wb_t             wb, wb_nxt;
  logic            is_mem, aligned, timed_out;

  assign is_mem    = in_is_load | in_is_store;
  assign aligned   = (addr_in[1:0] == 2'b00);
  assign timed_out = (cnt == CW'(TIMEOUT - 1));
  assign mem_stall = (state == WAIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      lat   <= '0;
      bus   <= '0;
      wb    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == WAIT) ? cnt + 1'b1 : '0;
      lat   <= lat_nxt;
      bus   <= bus_nxt;
      wb    <= wb_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid && is_mem && aligned) state_nxt = WAIT;
      WAIT: if (dmem_ack || timed_out)         state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lat_nxt      = lat;
    bus_nxt      = bus;
    wb_nxt       = wb;
    wb_nxt.valid = 1'b0;
    wb_nxt.fault = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            wb_nxt = '{valid: 1'b1, we: 1'b1, instr: instruction_in, pc: progcounter_in,
                       data: dataC_in, fault: 1'b0};
          end else if (!aligned) begin
            wb_nxt = '{valid: 1'b1, we: 1'b0, instr: instruction_in, pc: progcounter_in,
                       data: '0, fault: 1'b1};
          end else begin
            lat_nxt = '{instr: instruction_in, pc: progcounter_in, is_load: in_is_load};
            bus_nxt = '{req: 1'b1, we: in_is_store, addr: addr_in,
                        wdata: in_is_store ? dataC_in : '0};
          end
        end
      end
      WAIT: begin
        // Ack on the timeout cycle still completes normally.
        if (dmem_ack) begin
          bus_nxt.req = 1'b0;
          wb_nxt = '{valid: 1'b1, we: lat.is_load, instr: lat.instr, pc: lat.pc,
                     data: lat.is_load ? dmem_rdata : '0, fault: 1'b0};
        end else if (timed_out) begin
          bus_nxt.req = 1'b0;
          wb_nxt = '{valid: 1'b1, we: 1'b0, instr: lat.instr, pc: lat.pc,
                     data: '0, fault: 1'b1};
        end
      end
      default: ;
    endcase
  end

  assign dmem_req       = bus.req;
  assign dmem_we        = bus.we;
  assign dmem_addr      = bus.addr;
  assign dmem_wdata     = bus.wdata;
  assign wb_valid       = wb.valid;
  assign wb_we          = wb.we;
  assign wb_instruction = wb.instr;
  assign wb_progcounter = wb.pc;
  assign wb_data        = wb.data;
  assign mem_fault      = wb.fault;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed corner cases then randomized ops, each scored against
// an outcome model derived from instruction kind, alignment and bus ack latency.
module tb_mem_access_stage;
  localparam int W  = 32;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           in_valid, in_is_load, in_is_store;
  logic [W-1:0]   instruction_in, dataC_in, addr_in;
  logic [W-3:0]   progcounter_in;
  logic           mem_stall, dmem_req, dmem_we;
  logic [W-1:0]   dmem_addr, dmem_wdata;
  logic           dmem_ack;
  logic [W-1:0]   dmem_rdata;
  logic           wb_valid, wb_we, mem_fault;
  logic [W-1:0]   wb_instruction, wb_data;
  logic [W-3:0]   wb_progcounter;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_is_load(in_is_load), .in_is_store(in_is_store),
    .instruction_in(instruction_in), .progcounter_in(progcounter_in),
    .dataC_in(dataC_in), .addr_in(addr_in),
    .mem_stall(mem_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_instruction(wb_instruction),
    .wb_progcounter(wb_progcounter), .wb_data(wb_data), .mem_fault(mem_fault)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Outcome of one instruction. kind: 0=ALU, 1=load, 2=store. lat>=TO means the bus never acks.
  function automatic void model(input int kind, input logic [W-1:0] addr, input logic [W-1:0] dc,
                                input logic [W-1:0] rd, input int lat,
                                output logic fault, output logic we, output logic [W-1:0] data,
                                output int stalls);
    bit acked = (lat < TO);
    if (kind == 0) begin
      fault = 0; we = 1; data = dc; stalls = 0;
    end else if (addr % 4 != 0) begin
      fault = 1; we = 0; data = 0; stalls = 0;
    end else begin
      stalls = acked ? lat + 1 : TO;
      fault  = !acked;
      we     = acked && kind == 1;
      data   = (acked && kind == 1) ? rd : 0;
    end
  endfunction

  // Called at a negedge; returns at the negedge where the result is visible on the WB side.
  task automatic run_op(input int kind, input logic [W-1:0] instr, input logic [W-3:0] pc,
                        input logic [W-1:0] addr, input logic [W-1:0] dc, input int lat,
                        input logic [W-1:0] rd);
    logic e_fault, e_we;
    logic [W-1:0] e_data;
    int e_stalls, cycles;
    bit bus_op;
    model(kind, addr, dc, rd, lat, e_fault, e_we, e_data, e_stalls);
    bus_op = (kind != 0) && (addr % 4 == 0);
    in_valid = 1; in_is_load = (kind == 1); in_is_store = (kind == 2);
    instruction_in = instr; progcounter_in = pc; addr_in = addr; dataC_in = dc;
    @(negedge clk);
    // Upstream contents are don't-care from here on; scramble them to show they are ignored.
    in_valid = 0; instruction_in = $urandom; addr_in = $urandom; dataC_in = $urandom;
    in_is_load = 0; in_is_store = 0;
    cycles = 0;
    while (mem_stall && cycles < 64) begin
      chk1("req_held", dmem_req, 1'b1);
      chk1("bus_we", dmem_we, kind == 2);
      chk("bus_addr", dmem_addr, addr);
      chk("bus_wdata", dmem_wdata, (kind == 2) ? dc : 0);
      chk1("no_wb_in_wait", wb_valid, 1'b0);
      dmem_ack = (cycles == lat);
      dmem_rdata = (cycles == lat) ? rd : $urandom;
      @(negedge clk);
      cycles++;
    end
    dmem_ack = 0;
    chk("stall_cycles", 32'(cycles), 32'(e_stalls));
    if (!bus_op) chk1("no_req", dmem_req, 1'b0);
    chk1("req_dropped", dmem_req, 1'b0);
    chk1("stall_low", mem_stall, 1'b0);
    chk1("wb_valid", wb_valid, 1'b1);
    chk1("wb_we", wb_we, e_we);
    chk("wb_data", wb_data, e_data);
    chk1("mem_fault", mem_fault, e_fault);
    chk("wb_instr", wb_instruction, instr);
    chk("wb_pc", {2'b00, wb_progcounter}, {2'b00, pc});
  endtask

  task automatic bubble(input logic stray_ack);
    in_valid = 0; dmem_ack = stray_ack; dmem_rdata = $urandom;
    @(negedge clk);
    dmem_ack = 0;
    chk1("bubble_valid", wb_valid, 1'b0);
    chk1("bubble_fault", mem_fault, 1'b0);
    chk1("bubble_req", dmem_req, 1'b0);
    chk1("bubble_stall", mem_stall, 1'b0);
  endtask

  initial begin
    reset_n = 0; in_valid = 0; in_is_load = 0; in_is_store = 0;
    instruction_in = 0; progcounter_in = 0; dataC_in = 0; addr_in = 0;
    dmem_ack = 0; dmem_rdata = 0;

    @(negedge clk);
    chk1("rst_stall", mem_stall, 1'b0);
    chk1("rst_req", dmem_req, 1'b0);
    chk1("rst_valid", wb_valid, 1'b0);
    chk1("rst_fault", mem_fault, 1'b0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_data", wb_data, 0);
    reset_n = 1;
    @(negedge clk);

    run_op(0, 32'h0000_0013, 30'h10, 32'h0, 32'h0000_1234, 0, 0);
    bubble(1'b0);
    run_op(1, 32'h0000_2003, 30'h11, 32'h100, 32'h5555_0000, 3, 32'hDEAD_BEEF);
    run_op(2, 32'h0000_2023, 30'h12, 32'h200, 32'hA5A5_A5A5, 1, 32'h1111_1111);
    run_op(1, 32'h0000_2083, 30'h13, 32'h102, 32'h0, 0, 32'h2222_2222);
    bubble(1'b1);
    run_op(1, 32'h0000_2103, 30'h14, 32'h300, 32'h0, TO, 32'h3333_3333);
    run_op(1, 32'h0000_2183, 30'h15, 32'h304, 32'h0, TO - 1, 32'h4444_4444);
    run_op(2, 32'h0000_21A3, 30'h16, 32'h308, 32'h7777_7777, 0, 32'h0);
    run_op(0, 32'h0000_0033, 30'h17, 32'h0, 32'hFFFF_FFFF, 0, 0);

    // Reset while a load is outstanding.
    in_valid = 1; in_is_load = 1; in_is_store = 0; addr_in = 32'h400;
    instruction_in = 32'h0000_2203; progcounter_in = 30'h20; dataC_in = 0;
    @(negedge clk);
    in_valid = 0; in_is_load = 0;
    @(negedge clk);
    chk1("pre_rst_req", dmem_req, 1'b1);
    #2 reset_n = 0;
    #1;
    chk1("midrst_req", dmem_req, 1'b0);
    chk1("midrst_valid", wb_valid, 1'b0);
    chk1("midrst_stall", mem_stall, 1'b0);
    @(negedge clk);
    reset_n = 1;
    dmem_ack = 1;
    @(negedge clk);
    dmem_ack = 0;
    chk1("postrst_stall", mem_stall, 1'b0);
    chk1("postrst_valid", wb_valid, 1'b0);
    chk1("postrst_req", dmem_req, 1'b0);
    run_op(0, 32'h0000_0093, 30'h21, 32'h0, 32'hCAFE_F00D, 0, 0);

    for (int i = 0; i < 80; i++) begin
      int sel, kind, lat;
      logic [W-1:0] a;
      sel = $urandom_range(0, 9);
      kind = $urandom_range(0, 2);
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a = a & ~32'h3;
      if (sel < 7)       lat = $urandom_range(0, 5);
      else if (sel == 7) lat = TO - 1;
      else if (sel == 8) lat = TO;
      else               lat = $urandom_range(0, TO - 2);
      if ($urandom_range(0, 5) == 0) bubble($urandom_range(0, 1) == 1);
      run_op(kind, $urandom, 30'($urandom), a, $urandom, lat, $urandom);
    end
    bubble(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
